// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
// Accepts a 512-bit padded block as two 256-bit beats (upper half first) and
// emits the 64 schedule words W[0..63] one per accepted cycle, keeping a
// 16-word sliding window that is extended on every word transfer.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// LOAD_UPPER | waiting for the upper beat (block words 0..7)
// LOAD_LOWER | waiting for the lower beat (block words 8..15)
// EMIT       | presenting W[t] from window word 0, t = round counter
module sha256_msg_sched #(
  parameter int SHA_IF_DATA_W = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     src_sched_data_val,
  input  logic [SHA_IF_DATA_W-1:0] src_sched_data,
  input  logic                     src_sched_data_last,
  output logic                     sched_src_rdy,
  output logic                     sched_dst_w_val,
  output logic [31:0]              sched_dst_w,
  output logic [5:0]               sched_dst_w_idx,
  output logic                     sched_dst_w_last,
  output logic                     sched_dst_msg_last,
  input  logic                     dst_sched_w_rdy,
  output logic                     sched_err
);

  typedef enum logic [1:0] {
    LOAD_UPPER = 2'd0,
    LOAD_LOWER = 2'd1,
    EMIT       = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic        msg_last_q, msg_last_d;
  logic        err_q, err_d;
  logic [31:0] w_new;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // Next window word produced by the recurrence on every word transfer.
  always_comb begin
    w_new = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
  end

  // Next-state, window update and handshake outputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    win_d           = win_q;
    msg_last_d      = msg_last_q;
    err_d           = err_q;
    sched_src_rdy   = 1'b0;
    sched_dst_w_val = 1'b0;
    case (state_q)
      LOAD_UPPER: begin
        sched_src_rdy = 1'b1;
        if (src_sched_data_val) begin
          for (int k = 0; k < 8; k++) begin
            win_d[k] = src_sched_data[SHA_IF_DATA_W-1-32*k -: 32];
          end
          // A final-beat marker on an upper half is a framing error; the
          // block is still taken so the downstream sees a full schedule.
          if (src_sched_data_last) err_d = 1'b1;
          state_d = LOAD_LOWER;
        end
      end
      LOAD_LOWER: begin
        sched_src_rdy = 1'b1;
        if (src_sched_data_val) begin
          for (int k = 0; k < 8; k++) begin
            win_d[8+k] = src_sched_data[SHA_IF_DATA_W-1-32*k -: 32];
          end
          msg_last_d = src_sched_data_last;
          cnt_d      = 6'd0;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        sched_dst_w_val = 1'b1;
        if (dst_sched_w_rdy) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_new;
          if (cnt_q == 6'd63) begin
            cnt_d   = 6'd0;
            state_d = LOAD_UPPER;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = LOAD_UPPER;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_UPPER;
      cnt_q      <= 6'd0;
      msg_last_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      msg_last_q <= msg_last_d;
      err_q      <= err_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign sched_dst_w        = win_q[0];
  assign sched_dst_w_idx    = cnt_q;
  assign sched_dst_w_last   = (state_q == EMIT) && (cnt_q == 6'd63);
  assign sched_dst_msg_last = msg_last_q;
  assign sched_err          = err_q;

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 SHALL have parameter SHA_IF_DATA_W, default 256, input beat width; only 256 is supported.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port src_sched_data_val  input  1  upstream beat valid.
REQ-005 SHALL have port src_sched_data  input  256  padded message beat; upper beat of a block first.
REQ-006 SHALL have port src_sched_data_last  input  1  beat is the final beat of the message.
REQ-007 SHALL have port sched_src_rdy  output  1  schedule can accept a beat.
REQ-008 SHALL have port sched_dst_w_val  output  1  schedule word valid.
REQ-009 SHALL have port sched_dst_w  output  32  schedule word W[t].
REQ-010 SHALL have port sched_dst_w_idx  output  6  round index t, 0..63.
REQ-011 SHALL have port sched_dst_w_last  output  1  high when t==63.
REQ-012 SHALL have port sched_dst_msg_last  output  1  current block is the final block of the message; valid with sched_dst_w_val.
REQ-013 SHALL have port dst_sched_w_rdy  input  1  downstream accepts word.
REQ-014 SHALL have port sched_err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement states LOAD_UPPER, LOAD_LOWER, EMIT.
REQ-016 Beat transfer SHALL occur when src_sched_data_val & sched_src_rdy; word transfer SHALL occur when sched_dst_w_val & dst_sched_w_rdy.
REQ-017 sched_src_rdy SHALL be 1 in LOAD_UPPER and LOAD_LOWER and 0 in EMIT; sched_dst_w_val SHALL be 1 only in EMIT.
REQ-018 LOAD_UPPER beat transfer SHALL load window words 0..7, with word k = data[255-32k -: 32] (big-endian), then go to LOAD_LOWER.
REQ-019 LOAD_LOWER beat transfer SHALL load window words 8..15 by the same mapping, latch src_sched_data_last into the msg_last register, clear the round counter to 0, and go to EMIT.
REQ-020 No transfer in a LOAD state SHALL leave that state and all registers unchanged.
REQ-021 src_sched_data_last=1 on an upper-beat transfer SHALL set sched_err; the beat is still loaded and the FSM still goes to LOAD_LOWER.
REQ-022 In EMIT, sched_dst_w SHALL equal window word 0, sched_dst_w_idx SHALL equal the round counter, and sched_dst_msg_last SHALL equal the latched msg_last.
REQ-023 On an EMIT word transfer, the window SHALL shift down one word (word i <- word i+1), word 15 <- s1(word14) + word9 + s0(word1) + word0 mod 2^32, and the counter SHALL increment.
REQ-024 s0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x); s1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-025 An EMIT word transfer with counter==63 SHALL go to LOAD_UPPER; the counter SHALL NOT wrap within EMIT.
REQ-026 If dst_sched_w_rdy=0 in EMIT, all outputs and the window SHALL hold stable.
REQ-027 Latency SHALL be: W[0] valid the cycle after the lower-beat transfer; one word per cycle under continuous rdy; 66 cycles per block minimum.
REQ-028 A block SHALL be accepted in LOAD_UPPER on the cycle after W[63] transfers; no LOAD/EMIT overlap.

Reset
REQ-029 While rst=1, the next edge SHALL set state LOAD_UPPER, counter 0, window 0, msg_last 0, and sched_err 0.
REQ-030 After reset, outputs SHALL be: sched_src_rdy=1, sched_dst_w_val=0, sched_dst_w=0, sched_dst_w_idx=0, sched_dst_w_last=0, sched_dst_msg_last=0, sched_err=0.
REQ-031 rst asserted mid-block (any state, any counter) SHALL abandon the block with no further words emitted.

Verification
REQ-032 "abc" block: upper=0x61626380_00..00, lower=0x00..00_00000018, last=1 -> W0=0x61626380, W1..W14=0, W15=0x00000018, W16=0x61626380, W17=0x000F0000, msg_last=1, W63 with w_last=1.
REQ-033 Random dst_sched_w_rdy backpressure on the "abc" block -> identical 64-word sequence, outputs stable while stalled, idx strictly 0..63.
REQ-034 Two-block message, back-to-back (last=0 then last=1) -> msg_last 0 for block 1 and 1 for block 2; rdy reasserts the cycle after W63 of block 1.
REQ-035 last=1 on an upper beat -> sched_err=1 and stays 1 until rst; block still emits 64 words.
REQ-036 rst at idx=30 -> next cycle val=0, rdy=1; a following block emits from W0 correctly.
REQ-037 Random blocks vs a reference model of FIPS 180-4 section 6.2.2 -> all 64 words match.
